// File: rtl/synth_pkg.sv
// ============================================================================
//  synth_pkg
//  Shared types, constants and helpers for the synthesizer sample path.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package synth_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        WAIT    = 2'd2,
        CAPTURE = 2'd3
    } play_state_t;

    localparam int ROM_LATENCY = 1;

    // Offset-binary to two's complement: flipping the MSB subtracts 2**(w-1) modulo 2**w.
    function automatic logic [31:0] ob_to_signed(input logic [31:0] v, input int w);
        return v ^ (32'd1 << (w - 1));
    endfunction

endpackage

`default_nettype wire

// File: rtl/metronome_player_beat_counter.sv
// ============================================================================
//  beat_counter
//  Counts sample ticks into beats at a programmable period and tracks bar position.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module beat_counter
    import synth_pkg::*;
#(
    parameter int PERIOD_W = 20
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                tick,
    input  logic                active,
    input  logic [PERIOD_W-1:0] beat_period,
    input  logic [2:0]          beats_per_bar,
    output logic                fire,
    output logic                beat,
    output logic [2:0]          beat_index
);

    logic [PERIOD_W-1:0] r_count;
    logic                r_armed;
    logic                w_last;
    logic [2:0]          w_bar_last;
    logic [2:0]          w_next_index;

    // Comparing with >= lets a shortened period take effect on the very next tick.
    assign w_last       = (r_count >= (beat_period - PERIOD_W'(1)));
    assign fire         = tick && active && (r_armed || w_last);
    assign w_bar_last   = (beats_per_bar == 3'd0) ? 3'd0 : (beats_per_bar - 3'd1);
    assign w_next_index = r_armed ? 3'd0 :
                          ((beat_index >= w_bar_last) ? 3'd0 : (beat_index + 3'd1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count    <= '0;
            r_armed    <= 1'b1;
            beat       <= 1'b0;
            beat_index <= 3'd0;
        end else if (!active) begin
            r_count    <= '0;
            r_armed    <= 1'b1;
            beat       <= 1'b0;
            beat_index <= 3'd0;
        end else begin
            beat <= fire;
            if (tick) begin
                if (fire) begin
                    r_count    <= '0;
                    r_armed    <= 1'b0;
                    beat_index <= w_next_index;
                end else begin
                    r_count <= r_count + PERIOD_W'(1);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/metronome_player.sv
// ============================================================================
//  metronome_player
//  Beat generation plus click ROM playback into a signed, volume-scaled sample.
//  Optional feature macro: ACCENT_EN (downbeat click doubled with saturation).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module metronome_player
    import synth_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int ADDR_WIDTH = 14,
    parameter  int CLICK_LEN  = 16384,
    parameter  int PERIOD_W   = 20,
    localparam int OUT_W      = DATA_WIDTH + 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    sample_tick,
    input  logic [PERIOD_W-1:0]     beat_period,
    input  logic [7:0]              volume,
    input  logic [2:0]              beats_per_bar,
    output logic [ADDR_WIDTH-1:0]   rom_addr,
    input  logic [DATA_WIDTH-1:0]   rom_q,
    output logic signed [OUT_W-1:0] sample_out,
    output logic                    sample_valid,
    output logic                    beat,
    output logic [2:0]              beat_index
);

    localparam logic [ADDR_WIDTH-1:0] c_last_pos = ADDR_WIDTH'(CLICK_LEN - 1);

    play_state_t             r_state;
    play_state_t             w_next;
    logic                    w_active;
    logic                    w_fire;
    logic                    w_start;
    logic                    r_playing;
    logic                    r_fetch_play;
    logic [ADDR_WIDTH-1:0]   r_pos;
    logic [ADDR_WIDTH-1:0]   w_fetch_pos;
    logic signed [DATA_WIDTH-1:0] w_centered;
    logic signed [OUT_W-1:0] w_cent_ext;
    logic signed [OUT_W-1:0] w_vol_ext;
    logic signed [OUT_W-1:0] w_product;
    logic signed [OUT_W-1:0] w_scaled;

    assign w_active = enable && (beat_period != '0);
    assign w_start  = (r_state == IDLE) && sample_tick;

    beat_counter #(
        .PERIOD_W (PERIOD_W)
    ) u_beat_counter (
        .clk           (clk),
        .reset_n       (reset_n),
        .tick          (sample_tick),
        .active        (w_active),
        .beat_period   (beat_period),
        .beats_per_bar (beats_per_bar),
        .fire          (w_fire),
        .beat          (beat),
        .beat_index    (beat_index)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (sample_tick) w_next = FETCH;
            FETCH:   w_next = WAIT;
            WAIT:    w_next = CAPTURE;
            CAPTURE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_centered = DATA_WIDTH'(ob_to_signed(32'(rom_q), DATA_WIDTH));
    assign w_cent_ext = {{(OUT_W - DATA_WIDTH){w_centered[DATA_WIDTH-1]}}, w_centered};
    assign w_vol_ext  = {{(OUT_W - 8){1'b0}}, volume};
    assign w_product  = w_cent_ext * w_vol_ext;

`ifdef ACCENT_EN
    localparam logic [OUT_W-1:0] c_sat_max = {1'b0, {(OUT_W - 1){1'b1}}};
    localparam logic [OUT_W-1:0] c_sat_min = {1'b1, {(OUT_W - 1){1'b0}}};

    logic               r_accent;
    logic signed [OUT_W:0] w_doubled;

    // The registered beat pulse follows the trigger by one cycle, well before capture.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_accent <= 1'b0;
        end else if (beat) begin
            r_accent <= (beat_index == 3'd0);
        end
    end

    assign w_doubled = {w_product, 1'b0};

    always_comb begin
        w_scaled = w_product;
        if (r_accent) begin
            if (w_doubled[OUT_W] != w_doubled[OUT_W-1]) begin
                w_scaled = w_doubled[OUT_W] ? c_sat_min : c_sat_max;
            end else begin
                w_scaled = w_doubled[OUT_W-1:0];
            end
        end
    end
`else
    assign w_scaled = w_product;
`endif

    // A beat on this tick restarts the click, so its fetch uses address 0.
    assign w_fetch_pos = w_fire ? '0 : r_pos;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rom_addr     <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            r_playing    <= 1'b0;
            r_fetch_play <= 1'b0;
            r_pos        <= '0;
        end else begin
            sample_valid <= (r_state == CAPTURE);
            if (r_state == CAPTURE) begin
                sample_out <= r_fetch_play ? w_scaled : '0;
            end

            if (!w_active) begin
                r_playing    <= 1'b0;
                r_fetch_play <= 1'b0;
                r_pos        <= '0;
                if (w_start) begin
                    rom_addr <= '0;
                end
            end else if (w_start) begin
                if (w_fire || r_playing) begin
                    rom_addr     <= w_fetch_pos;
                    r_fetch_play <= 1'b1;
                    if (w_fetch_pos == c_last_pos) begin
                        r_playing <= 1'b0;
                        r_pos     <= '0;
                    end else begin
                        r_playing <= 1'b1;
                        r_pos     <= w_fetch_pos + ADDR_WIDTH'(1);
                    end
                end else begin
                    rom_addr     <= '0;
                    r_fetch_play <= 1'b0;
                end
            end else if (w_fire) begin
                r_playing <= 1'b1;
                r_pos     <= '0;
            end
        end
    end

endmodule

`default_nettype wire
